// File: rtl/ram_pkg.sv
// Shared types and constants for the ram block and its read-side scan sequencer.
package ram_pkg;

  localparam int BYTE_SZ       = 8;
  localparam int MAX_STRING_SZ = 8;

  // One RAM word holds an 8-character string in the 64-bit build.
  typedef logic [BYTE_SZ*MAX_STRING_SZ-1:0] CHAR;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EMIT0,
    S_EMIT1,
    S_DONE
  } scan_state_t;

endpackage

// File: rtl/ram_scan_ctrl.sv
// Sweeps a dual-port RAM two addresses per pass and streams its words out on valid/ready.
// RAM_SCAN_SKIP_ZERO_EN: when defined, zero words are dropped instead of emitted.
module ram_scan_ctrl
  import ram_pkg::*;
#(
  parameter int DATAWIDTH = 64,
  parameter int ADDRWIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 en_r1_n,
  output logic                 en_r2_n,
  output logic [ADDRWIDTH-1:0] addr_r1,
  output logic [ADDRWIDTH-1:0] addr_r2,
  input  logic [DATAWIDTH-1:0] data_r1,
  input  logic [DATAWIDTH-1:0] data_r2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDRWIDTH-1:0] out_addr,
  output logic [DATAWIDTH-1:0] out_data,
  output logic [ADDRWIDTH:0]   out_count
);

  localparam logic [ADDRWIDTH-1:0] LAST_BASE = ADDRWIDTH'(2**ADDRWIDTH - 2);
  localparam logic [ADDRWIDTH:0]   DEPTH     = (ADDRWIDTH+1)'(2**ADDRWIDTH);
  localparam logic [ADDRWIDTH-1:0] ONE       = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] TWO       = ADDRWIDTH'(2);

  scan_state_t          state_q, state_d;
  logic [ADDRWIDTH-1:0] base_q, base_d;
  logic [DATAWIDTH-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic                 keep0_q, keep0_d, keep1_q, keep1_d;
  logic [ADDRWIDTH:0]   count_q, count_d;
  logic                 busy_q, busy_d, done_q, done_d, en_n_q, en_n_d;
  logic [ADDRWIDTH-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic                 keep_r1, keep_r2, hs;

`ifdef RAM_SCAN_SKIP_ZERO_EN
  assign keep_r1 = |data_r1;
  assign keep_r2 = |data_r2;
`else
  assign keep_r1 = 1'b1;
  assign keep_r2 = 1'b1;
`endif

  // The stream is a decode of the slot registers, so it holds stable through a stall.
  assign out_valid = ((state_q == S_EMIT0) && keep0_q) || ((state_q == S_EMIT1) && keep1_q);
  assign out_data  = (state_q == S_EMIT1) ? slot1_q : slot0_q;
  assign out_addr  = (state_q == S_EMIT1) ? base_q + ONE : base_q;
  assign hs        = out_valid && out_ready;

  assign busy      = busy_q;
  assign done      = done_q;
  assign en_r1_n   = en_n_q;
  assign en_r2_n   = en_n_q;
  assign addr_r1   = addr1_q;
  assign addr_r2   = addr2_q;
  assign out_count = count_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    keep0_d = keep0_q;
    keep1_d = keep1_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    en_n_d  = 1'b1;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          base_d  = '0;
          count_d = '0;
          busy_d  = 1'b1;
          en_n_d  = 1'b0;
          addr1_d = '0;
          addr2_d = ONE;
        end
      end
      S_READ: begin
        slot0_d = data_r1;
        slot1_d = data_r2;
        keep0_d = keep_r1;
        keep1_d = keep_r2;
        state_d = S_EMIT0;
      end
      S_EMIT0: begin
        if (!keep0_q || out_ready) state_d = S_EMIT1;
      end
      S_EMIT1: begin
        if (!keep1_q || out_ready) begin
          if (base_q == LAST_BASE) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            base_d  = base_q + TWO;
            en_n_d  = 1'b0;
            addr1_d = base_q + TWO;
            addr2_d = base_q + TWO + ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (hs && count_q != DEPTH) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
      keep0_q <= 1'b0;
      keep1_q <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_n_q  <= 1'b1;
      addr1_q <= '0;
      addr2_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      keep0_q <= keep0_d;
      keep1_q <= keep1_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_n_q  <= en_n_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
    end
  end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Bench for ram_scan_ctrl: table of RAM images swept against a scoreboard, plus a mid-sweep reset.
module tb_ram_scan_ctrl;
  import ram_pkg::*;

  localparam int DW = 64;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic          busy, done, en_r1_n, en_r2_n, out_valid;
  logic [AW-1:0] addr_r1, addr_r2, out_addr;
  logic [DW-1:0] data_r1, data_r2, out_data;
  logic [AW:0]   out_count;
  logic [DW-1:0] mem [8];

  always #5 clk = ~clk;

  assign data_r1 = en_r1_n ? '0 : mem[addr_r1];
  assign data_r2 = en_r2_n ? '0 : mem[addr_r2];

  ram_scan_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .en_r1_n(en_r1_n), .en_r2_n(en_r2_n), .addr_r1(addr_r1), .addr_r2(addr_r2),
    .data_r1(data_r1), .data_r2(data_r2), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_count(out_count)
  );

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } exp_t;
  typedef struct { logic [7:0][DW-1:0] m; bit stall; bit restart; string name; } vec_t;

  exp_t q[$];
  vec_t tbl[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][DW-1:0] basic_img();
    logic [7:0][DW-1:0] m;
    m    = '0;
    m[0] = CHAR'("Nesrine");
    m[1] = CHAR'("Sridhar");
    m[2] = CHAR'("Yong");
    m[3] = CHAR'("Rupkatha");
    m[4] = CHAR'("Aart");
    return m;
  endfunction

  function automatic bit kept(input logic [DW-1:0] w);
`ifdef RAM_SCAN_SKIP_ZERO_EN
    return w != '0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_sweep(input vec_t v);
    int   n_exp, stall_left, done_cyc, exp_done;
    bit   prev_stall;
    exp_t prev, e;
    logic [AW-1:0] last_a1, last_a2;
    n_exp = 0;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      mem[i] = v.m[i];
      if (kept(v.m[i])) begin
        q.push_back('{a: AW'(i), d: v.m[i]});
        n_exp++;
      end
    end
    out_ready  = 1'b1;
    stall_left = v.stall ? 4 : 0;
    exp_done   = 13 + stall_left;
    done_cyc   = -1;
    prev_stall = 1'b0;
    prev       = '0;
    last_a1    = '0;
    last_a2    = '0;
    pulse_start();
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      start = v.restart && (cyc == 5);
      if (stall_left > 0 && out_valid && out_addr == AW'(1)) begin
        out_ready = 1'b0;
        stall_left--;
      end else out_ready = 1'b1;
      @(negedge clk);
      if (cyc == 1) begin
        chk({v.name, " busy_c1"}, 64'(busy), 64'd1);
        chk({v.name, " en_c1"}, 64'({en_r1_n, en_r2_n}), 64'd0);
        chk({v.name, " addr_c1"}, 64'({addr_r1, addr_r2}), 64'({3'd0, 3'd1}));
        chk({v.name, " valid_c1"}, 64'(out_valid), 64'd0);
      end
      if (prev_stall) begin
        chk({v.name, " hold_valid"}, 64'(out_valid), 64'd1);
        chk({v.name, " hold_addr"}, 64'(out_addr), 64'(prev.a));
        chk({v.name, " hold_data"}, out_data, prev.d);
      end
      prev_stall = out_valid && !out_ready;
      prev       = '{a: out_addr, d: out_data};
      if (!en_r1_n) begin last_a1 = addr_r1; last_a2 = addr_r2; end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk({v.name, " extra_word_addr"}, 64'(out_addr), 64'hFFFF);
        else begin
          e = q.pop_front();
          chk({v.name, " out_addr"}, 64'(out_addr), 64'(e.a));
          chk({v.name, " out_data"}, out_data, e.d);
        end
      end
      if (done) begin done_cyc = cyc; break; end
    end
    chk({v.name, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
    chk({v.name, " out_count"}, 64'(out_count), 64'(n_exp));
    chk({v.name, " words_missing"}, 64'(q.size()), 64'd0);
    chk({v.name, " last_read"}, 64'({last_a1, last_a2}), 64'({3'd6, 3'd7}));
    @(posedge clk); #1;
    @(negedge clk);
    chk({v.name, " done_pulse"}, 64'(done), 64'd0);
    chk({v.name, " busy_after"}, 64'(busy), 64'd0);
    chk({v.name, " count_hold"}, 64'(out_count), 64'(n_exp));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    tbl[0] = '{m: basic_img(), stall: 1'b0, restart: 1'b0, name: "basic"};
    tbl[1] = '{m: basic_img(), stall: 1'b1, restart: 1'b0, name: "backpressure"};
    tbl[2] = '{m: '0,          stall: 1'b0, restart: 1'b0, name: "empty"};
    tbl[3] = '{m: '0,          stall: 1'b0, restart: 1'b0, name: "boundary"};
    tbl[3].m[7] = 64'hCC;
    tbl[4] = '{m: basic_img(), stall: 1'b0, restart: 1'b1, name: "restart"};

    #23;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst valid", 64'(out_valid), 64'd0);
    chk("rst en", 64'({en_r1_n, en_r2_n}), 64'd3);
    chk("rst addr", 64'({addr_r1, addr_r2, out_addr}), 64'd0);
    chk("rst data", out_data, 64'd0);
    chk("rst count", 64'(out_count), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int t = 0; t < 5; t++) run_sweep(tbl[t]);

    // Reset while word 4 is stalled in EMIT0 with four words already accepted.
    for (int i = 0; i < 8; i++) mem[i] = tbl[0].m[i];
    out_ready = 1'b1;
    pulse_start();
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      out_ready = (cyc < 8);
      @(negedge clk);
    end
    chk("pre_rst valid", 64'(out_valid), 64'd1);
    chk("pre_rst addr", 64'(out_addr), 64'd4);
    chk("pre_rst count", 64'(out_count), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("async valid", 64'(out_valid), 64'd0);
    chk("async busy", 64'(busy), 64'd0);
    chk("async en", 64'({en_r1_n, en_r2_n}), 64'd3);
    chk("async count", 64'(out_count), 64'd0);
    chk("async data", out_data, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tbl[0].name = "fresh";
    run_sweep(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
